camera_frame_capture: RTL and testbench
=======================================

Name: camera_frame_capture

Overview:
- Upstream stage of colour recognition. Samples the OV7670-style parallel camera bus (PCLK, HREF, VSYNC, D[7:0]) in the system clock domain.
- Writes one RGB565 frame byte-by-byte into the frame RAM at byte addresses 0..N-1, high byte first.
- Signals the downstream analyser when a complete frame is in RAM, and holds the RAM unwritten until the analyser acknowledges.

Parameters:
- ADDR_W, 15, RAM byte-address width; matches the analyser's address bus.
- MAX_BYTES, 19200, RAM capacity in bytes (80x120 RGB565); must be <= 2^ADDR_W.

Ports:
- i_clk  in  1  system clock; must run at >= 4x camera PCLK.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  request capture of the next full frame; level, sampled in IDLE only.
- i_ack  in  1  analyser finished reading RAM; releases HOLD.
- i_cam_pclk  in  1  camera pixel clock, treated as data.
- i_cam_href  in  1  line-valid.
- i_cam_vsync  in  1  frame sync; high = vertical blanking.
- i_cam_data  in  8  camera byte.
- o_wr_en  out  1  one-cycle RAM write strobe.
- o_wr_addr  out  ADDR_W  RAM byte address.
- o_wr_data  out  8  RAM write byte.
- o_frame_ready  out  1  level; frame complete in RAM.
- o_byte_count  out  ADDR_W  bytes in the completed frame; always even.
- o_overflow  out  1  sticky; frame exceeded MAX_BYTES.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; write pointer 0.
  - Reset has priority over every other event in the same cycle.
  - Reset mid-capture abandons the frame. No further writes occur; RAM contents are undefined.
- Input pipeline:
  - pclk, href, vsync and data each pass through an identical 2-FF synchroniser, so they stay aligned.
  - PCLK rising edge = synchronised pclk is 1 and its previous-cycle value was 0.
- States:
  - IDLE: when i_start=1, clear o_overflow and the pointer, then go to WAIT_VS_HIGH.
  - WAIT_VS_HIGH: wait for synchronised vsync=1. This guarantees capture starts at a frame boundary.
  - WAIT_VS_LOW: on vsync falling edge, go to CAPTURE.
  - CAPTURE:
    - On each PCLK rising edge with href=1, if pointer < MAX_BYTES:
      - o_wr_en=1 for exactly one cycle, the cycle after the edge detect.
      - o_wr_addr = pointer; o_wr_data = synchronised data; pointer +1.
    - If pointer = MAX_BYTES: no write; o_overflow <= 1.
    - On vsync rising edge, go to HOLD.
  - HOLD:
    - o_frame_ready=1.
    - o_byte_count = pointer rounded down to even; an odd trailing byte is written but not counted.
    - On i_ack=1, drop o_frame_ready next cycle and return to IDLE.
    - i_start is ignored in HOLD.
- Latency: a camera PCLK edge at the pin produces o_wr_en 4 i_clk cycles later (2 sync + 1 edge detect + 1 register).
- Simultaneous events:
  - vsync rise and a PCLK edge in the same cycle: the byte is written, then the state goes to HOLD.
  - i_ack asserted outside HOLD has no effect.
- Pointer never wraps. The comparison uses ADDR_W+1 bits internally.
- Frame with zero href bytes: reaches HOLD with o_byte_count=0.
- o_wr_addr/o_wr_data hold their last values when o_wr_en=0.

Optional Feature:
- Macro CAM_HDECIM2_EN.
- Defined: horizontal decimation by 2. Pixel parity toggles every second captured byte and resets at each href rising edge. Only even pixels (byte pairs 0-1, 4-5, ...) are written; the pointer advances only on written bytes.
- Undefined: every href byte is written.

Decomposition:
- Shared package cam_pkg:
  - state enum (IDLE, WAIT_VS_HIGH, WAIT_VS_LOW, CAPTURE, HOLD)
  - CAM_ADDR_W=15
  - CAM_MAX_BYTES=19200
  - RGB565 byte-order constants (high byte first)
- Sub-module cam_sync_edge: parameterised-width 2-FF synchroniser plus rising/falling edge detect. Reused for pclk, href and vsync.

Test Plan:
- Nominal frame: start=1, vsync high→low, 4 lines x 8 bytes (data = 0x00..0x1F), PCLK = i_clk/4, then vsync high → 32 writes at addr 0..31 with data 0..31; o_frame_ready=1; o_byte_count=32; o_overflow=0.
- Mid-frame start: assert i_start while vsync=0 and href bytes are flowing → no writes until the vsync high→low sequence; first write at addr 0.
- Overflow: MAX_BYTES=16, send 20 bytes → writes only at addr 0..15; o_overflow=1; o_byte_count=16. Next i_start clears o_overflow.
- Odd trailing byte: send 7 bytes → 7 writes; o_byte_count=6.
- Handshake: hold i_ack=0 for 100 cycles in HOLD while a new frame arrives → no writes; i_ack pulse → o_frame_ready=0 next cycle, state IDLE. With CAM_HDECIM2_EN, an 8-byte line writes bytes 0,1,4,5 → addr 0..3.
- Reset mid-capture after 5 bytes → all outputs 0 next cycle; a subsequent start/frame begins at addr 0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera frame capture block.
// Optional feature macro used by the top level: CAM_HDECIM2_EN.
package cam_pkg;

  // RAM byte-address width shared with the colour analyser.
  localparam int CAM_ADDR_W = 15;

  // 80x120 pixels, two bytes per RGB565 pixel.
  localparam int CAM_MAX_BYTES = 19200;

  // RGB565 byte order on the camera bus and in RAM: high byte first.
  localparam int   CAM_BYTES_PER_PIXEL = 2;
  localparam logic CAM_RGB565_HI_BYTE  = 1'b0;  // byte index within a pixel
  localparam logic CAM_RGB565_LO_BYTE  = 1'b1;

  // Capture sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS_HIGH,
    WAIT_VS_LOW,
    CAPTURE,
    HOLD
  } cam_state_t;

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser with registered rising/falling edge detect.
// The level output q is delayed by one extra flop so that it lines up
// with rise/fall: in the cycle a bit's rise is high, q shows the new
// value. Pass several camera signals through one instance to keep them
// aligned with each other.
module cam_sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  // Synchroniser chain, then edge detect against the previous cycle's value.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
      q    <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      // NOTE: non-blocking so each stage samples the previous stage's pre-edge value.
      meta <= d;
      sync <= meta;
      q    <= sync;
      rise <= sync & ~q;
      fall <= ~sync & q;
    end
  end

endmodule

// File: rtl/camera_frame_capture.sv
// Captures one RGB565 frame from an OV7670-style parallel camera bus into
// the frame RAM (byte addresses 0..N-1, high byte first), then raises
// o_frame_ready and holds the RAM until the analyser acknowledges.
// Optional feature macro: CAM_HDECIM2_EN (horizontal decimation by 2).
module camera_frame_capture
  import cam_pkg::*;
#(
  parameter int ADDR_W    = CAM_ADDR_W,
  parameter int MAX_BYTES = CAM_MAX_BYTES
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_ack,
  input  logic              i_cam_pclk,
  input  logic              i_cam_href,
  input  logic              i_cam_vsync,
  input  logic [7:0]        i_cam_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_frame_ready,
  output logic [ADDR_W-1:0] o_byte_count,
  output logic              o_overflow,
  output logic              o_busy
);

  // One extra bit so the pointer can reach MAX_BYTES without wrapping.
  localparam int               PTR_W   = ADDR_W + 1;
  localparam logic [PTR_W-1:0] MAX_PTR = PTR_W'(MAX_BYTES);

  // Bit positions of the camera signals inside the shared synchroniser.
  localparam int PCLK_BIT  = 8;
  localparam int HREF_BIT  = 9;
  localparam int VSYNC_BIT = 10;

  logic [10:0] sync_q;
  logic [10:0] sync_rise;
  logic [10:0] sync_fall;

  logic       pclk_rise;
  logic       href_s;
  logic       href_rise;
  logic       vsync_s;
  logic       vsync_rise;
  logic       vsync_fall;
  logic [7:0] data_s;

  cam_state_t        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              keep_byte;

`ifdef CAM_HDECIM2_EN
  // Byte position within a pair of pixels: 0,1 = even pixel, 2,3 = odd pixel.
  logic [1:0] phase_q, phase_d, phase_now;
`endif

  // All camera signals share one synchroniser so they stay aligned.
  cam_sync_edge #(
    .WIDTH(11)
  ) u_sync (
    .clk   (i_clk),
    .reset (i_reset),
    .d     ({i_cam_vsync, i_cam_href, i_cam_pclk, i_cam_data}),
    .q     (sync_q),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  assign data_s     = sync_q[7:0];
  assign pclk_rise  = sync_rise[PCLK_BIT];
  assign href_s     = sync_q[HREF_BIT];
  assign href_rise  = sync_rise[HREF_BIT];
  assign vsync_s    = sync_q[VSYNC_BIT];
  assign vsync_rise = sync_rise[VSYNC_BIT];
  assign vsync_fall = sync_fall[VSYNC_BIT];

  // Edge outputs that no logic consumes (data bits, pclk/href falls, and
  // href rise when decimation is compiled out).
  logic unused_sync;
  assign unused_sync = ^{sync_q[PCLK_BIT], sync_rise[HREF_BIT:0], sync_fall[HREF_BIT:0]};

  // Next-state and next-output logic for the capture sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ready_d   = ready_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    keep_byte = 1'b1;
`ifdef CAM_HDECIM2_EN
    phase_d   = phase_q;
    phase_now = href_rise ? 2'd0 : phase_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_start) begin
          ovf_d   = 1'b0;
          ptr_d   = '0;
          state_d = WAIT_VS_HIGH;
        end
      end

      // Starting from blanking guarantees the capture begins on a frame boundary.
      WAIT_VS_HIGH: begin
        if (vsync_s) begin
          state_d = WAIT_VS_LOW;
        end
      end

      WAIT_VS_LOW: begin
        if (vsync_fall) begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
`ifdef CAM_HDECIM2_EN
        phase_d = phase_now;
`endif
        if (pclk_rise && href_s) begin
`ifdef CAM_HDECIM2_EN
          keep_byte = ~phase_now[1];
          phase_d   = phase_now + 2'd1;
`endif
          if (keep_byte) begin
            if (ptr_q < MAX_PTR) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q[ADDR_W-1:0];
              wr_data_d = data_s;
              ptr_d     = ptr_q + PTR_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        // A byte arriving with the vsync rise is still counted: ptr_d already
        // includes it. An odd trailing byte is written but not counted.
        if (vsync_rise) begin
          state_d = HOLD;
          ready_d = 1'b1;
          count_d = {ptr_d[ADDR_W-1:1], 1'b0};
        end
      end

      HOLD: begin
        if (i_ack) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over every other event.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ready_q   <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
`ifdef CAM_HDECIM2_EN
      phase_q   <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ready_q   <= ready_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
`ifdef CAM_HDECIM2_EN
      phase_q   <= phase_d;
`endif
    end
  end

  assign o_wr_en       = wr_en_q;
  assign o_wr_addr     = wr_addr_q;
  assign o_wr_data     = wr_data_q;
  assign o_frame_ready = ready_q;
  assign o_byte_count  = count_q;
  assign o_overflow    = ovf_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_camera_frame_capture.sv
// Directed testbench for camera_frame_capture. Two instances share the
// camera stimulus: one at full capacity, one with a 16-byte RAM for the
// overflow scenario.
module tb_camera_frame_capture;

  localparam int ADDR_W    = 15;
  localparam int MAX_BIG   = 19200;
  localparam int MAX_SMALL = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset, start, ack, pclk, href, vsync;
  logic [7:0]        data;

  logic              wr_en, frame_ready, overflow, busy;
  logic [ADDR_W-1:0] wr_addr, byte_count;
  logic [7:0]        wr_data;

  logic              s_wr_en, s_frame_ready, s_overflow, s_busy;
  logic [ADDR_W-1:0] s_wr_addr, s_byte_count;
  logic [7:0]        s_wr_data;

  int  checks = 0;
  int  errors = 0;
  wr_t got_big[$], got_small[$], exp_big[$], exp_small[$];
  int  exp_ptr_big, exp_ptr_small;
  bit  exp_ovf_big, exp_ovf_small;

  camera_frame_capture #(.ADDR_W(ADDR_W), .MAX_BYTES(MAX_BIG)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_ack(ack),
    .i_cam_pclk(pclk), .i_cam_href(href), .i_cam_vsync(vsync), .i_cam_data(data),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_frame_ready(frame_ready), .o_byte_count(byte_count),
    .o_overflow(overflow), .o_busy(busy)
  );

  camera_frame_capture #(.ADDR_W(ADDR_W), .MAX_BYTES(MAX_SMALL)) dut_small (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_ack(ack),
    .i_cam_pclk(pclk), .i_cam_href(href), .i_cam_vsync(vsync), .i_cam_data(data),
    .o_wr_en(s_wr_en), .o_wr_addr(s_wr_addr), .o_wr_data(s_wr_data),
    .o_frame_ready(s_frame_ready), .o_byte_count(s_byte_count),
    .o_overflow(s_overflow), .o_busy(s_busy)
  );

  always #5 clk = ~clk;

  // Record RAM writes away from the active edge.
  always @(negedge clk) begin
    if (wr_en)   got_big.push_back(wr_t'({wr_addr, wr_data}));
    if (s_wr_en) got_small.push_back(wr_t'({s_wr_addr, s_wr_data}));
  end

  function automatic bit keep_byte(input int idx);
`ifdef CAM_HDECIM2_EN
    return (idx % 4) < 2;
`else
    return idx >= 0;
`endif
  endfunction

  task automatic model_clear();
    exp_big.delete();
    exp_small.delete();
    got_big.delete();
    got_small.delete();
    exp_ptr_big   = 0;
    exp_ptr_small = 0;
    exp_ovf_big   = 1'b0;
    exp_ovf_small = 1'b0;
  endtask

  // Expected effect of one href byte at position idx within its line.
  task automatic model_byte(input int idx, input logic [7:0] d);
    if (keep_byte(idx)) begin
      if (exp_ptr_big < MAX_BIG) begin
        exp_big.push_back(wr_t'({ADDR_W'(exp_ptr_big), d}));
        exp_ptr_big++;
      end else exp_ovf_big = 1'b1;
      if (exp_ptr_small < MAX_SMALL) begin
        exp_small.push_back(wr_t'({ADDR_W'(exp_ptr_small), d}));
        exp_ptr_small++;
      end else exp_ovf_small = 1'b1;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One camera byte with PCLK = clk/4: two cycles low, two cycles high.
  task automatic cam_byte(input logic [7:0] d);
    data = d;
    pclk = 1'b0;
    cycles(2);
    pclk = 1'b1;
    cycles(2);
  endtask

  task automatic send_line(input int n, input int base, input bit model);
    href = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (model) model_byte(i, 8'(base + i));
      cam_byte(8'(base + i));
    end
    href = 1'b0;
    pclk = 1'b0;
    cycles(4);
  endtask

  task automatic send_frame(input int lines, input int bpl, input int base);
    vsync = 1'b1;
    cycles(8);
    vsync = 1'b0;
    cycles(8);
    for (int l = 0; l < lines; l++) send_line(bpl, base + l * bpl, 1'b1);
    vsync = 1'b1;
    cycles(12);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    cycles(1);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycles(4);
    checks++;
    if ({wr_en, wr_addr, wr_data, frame_ready, byte_count, overflow, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {wr_en, wr_addr, wr_data, frame_ready, byte_count, overflow, busy});
    end
    reset = 1'b0;
    cycles(4);
    checks++;
    if ({s_wr_en, s_frame_ready, s_overflow, s_busy, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got %b, expected 00000",
               {s_wr_en, s_frame_ready, s_overflow, s_busy, busy});
    end
  endtask

  task automatic test_nominal();
    model_clear();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL nominal_busy: got %b, expected 1", busy);
    end
    send_frame(4, 8, 0);
    checks++;
    if (got_big.size() != exp_big.size()) begin
      errors++;
      $display("FAIL nominal_write_count: got %0d, expected %0d", got_big.size(), exp_big.size());
    end
    for (int i = 0; i < exp_big.size() && i < got_big.size(); i++) begin
      checks++;
      if (got_big[i] !== exp_big[i]) begin
        errors++;
        $display("FAIL nominal_write[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, got_big[i].addr, got_big[i].data, exp_big[i].addr, exp_big[i].data);
      end
    end
    checks++;
    if ({frame_ready, byte_count, overflow} !== {1'b1, ADDR_W'(exp_ptr_big & ~1), exp_ovf_big}) begin
      errors++;
      $display("FAIL nominal_status: got ready %b count %0d ovf %b, expected ready 1 count %0d ovf %b",
               frame_ready, byte_count, overflow, exp_ptr_big & ~1, exp_ovf_big);
    end
    pulse_ack();
    checks++;
    if ({frame_ready, busy} !== 2'b00) begin
      errors++;
      $display("FAIL nominal_ack: got ready %b busy %b, expected 0 0", frame_ready, busy);
    end
  endtask

  task automatic test_mid_frame_start();
    model_clear();
    pulse_start();
    send_line(8, 8'h60, 1'b0);
    checks++;
    if (got_big.size() != 0) begin
      errors++;
      $display("FAIL midstart_no_early_write: got %0d writes, expected 0", got_big.size());
    end
    send_frame(1, 8, 8'hA0);
    checks++;
    if (got_big.size() == 0 || got_big[0] !== exp_big[0]) begin
      errors++;
      $display("FAIL midstart_first_write: got %0d writes (first %h), expected first %h",
               got_big.size(), (got_big.size() > 0) ? got_big[0] : wr_t'(0), exp_big[0]);
    end
    checks++;
    if (got_big.size() != exp_big.size() || byte_count !== ADDR_W'(exp_ptr_big & ~1)) begin
      errors++;
      $display("FAIL midstart_frame: got %0d writes count %0d, expected %0d writes count %0d",
               got_big.size(), byte_count, exp_big.size(), exp_ptr_big & ~1);
    end
    pulse_ack();
  endtask

  task automatic test_overflow();
    model_clear();
    pulse_start();
    send_frame(1, 20, 8'h40);
    checks++;
    if (got_small.size() != exp_small.size()) begin
      errors++;
      $display("FAIL overflow_write_count: got %0d, expected %0d", got_small.size(), exp_small.size());
    end
    for (int i = 0; i < exp_small.size() && i < got_small.size(); i++) begin
      checks++;
      if (got_small[i] !== exp_small[i]) begin
        errors++;
        $display("FAIL overflow_write[%0d]: got %h, expected %h", i, got_small[i], exp_small[i]);
      end
    end
    checks++;
    if ({s_overflow, s_byte_count} !== {exp_ovf_small, ADDR_W'(exp_ptr_small & ~1)}) begin
      errors++;
      $display("FAIL overflow_status: got ovf %b count %0d, expected ovf %b count %0d",
               s_overflow, s_byte_count, exp_ovf_small, exp_ptr_small & ~1);
    end
    checks++;
    if ({overflow, byte_count} !== {exp_ovf_big, ADDR_W'(exp_ptr_big & ~1)}) begin
      errors++;
      $display("FAIL overflow_big_status: got ovf %b count %0d, expected ovf %b count %0d",
               overflow, byte_count, exp_ovf_big, exp_ptr_big & ~1);
    end
    pulse_ack();
    pulse_start();
    checks++;
    if ({s_overflow, s_busy} !== 2'b01) begin
      errors++;
      $display("FAIL overflow_cleared_by_start: got ovf %b busy %b, expected 0 1", s_overflow, s_busy);
    end
  endtask

  // Runs from WAIT_VS_HIGH, left there by the overflow test.
  task automatic test_odd_byte();
    model_clear();
    send_frame(1, 7, 8'h70);
    checks++;
    if (got_big.size() != exp_big.size()) begin
      errors++;
      $display("FAIL odd_write_count: got %0d, expected %0d", got_big.size(), exp_big.size());
    end
    checks++;
    if ({frame_ready, byte_count} !== {1'b1, ADDR_W'(exp_ptr_big & ~1)}) begin
      errors++;
      $display("FAIL odd_byte_count: got ready %b count %0d, expected ready 1 count %0d",
               frame_ready, byte_count, exp_ptr_big & ~1);
    end
  endtask

  // Runs in HOLD, left there by the odd-byte test.
  task automatic test_handshake();
    logic [ADDR_W-1:0] held_count;
    held_count = ADDR_W'(exp_ptr_big & ~1);
    got_big.delete();
    pulse_start();
    vsync = 1'b0;
    cycles(8);
    send_line(8, 8'h90, 1'b0);
    send_line(8, 8'h98, 1'b0);
    vsync = 1'b1;
    cycles(10);
    checks++;
    if (got_big.size() != 0) begin
      errors++;
      $display("FAIL hold_no_writes: got %0d writes, expected 0", got_big.size());
    end
    checks++;
    if ({frame_ready, busy, byte_count} !== {2'b11, held_count}) begin
      errors++;
      $display("FAIL hold_status: got ready %b busy %b count %0d, expected 1 1 %0d",
               frame_ready, busy, byte_count, held_count);
    end
    pulse_ack();
    checks++;
    if ({frame_ready, busy} !== 2'b00) begin
      errors++;
      $display("FAIL hold_ack_release: got ready %b busy %b, expected 0 0", frame_ready, busy);
    end
    pulse_ack();
    checks++;
    if ({frame_ready, busy} !== 2'b00) begin
      errors++;
      $display("FAIL ack_in_idle: got ready %b busy %b, expected 0 0", frame_ready, busy);
    end
  endtask

  task automatic test_reset_mid_capture();
    model_clear();
    pulse_start();
    vsync = 1'b1;
    cycles(8);
    vsync = 1'b0;
    cycles(8);
    href = 1'b1;
    for (int i = 0; i < 5; i++) begin
      model_byte(i, 8'(8'hC0 + i));
      cam_byte(8'(8'hC0 + i));
    end
    cycles(6);
    checks++;
    if (got_big.size() != exp_big.size() || got_big[got_big.size()-1] !== exp_big[exp_big.size()-1]) begin
      errors++;
      $display("FAIL midreset_pre_writes: got %0d writes, expected %0d", got_big.size(), exp_big.size());
    end
    reset = 1'b1;
    cycles(1);
    checks++;
    if ({wr_en, wr_addr, wr_data, frame_ready, byte_count, overflow, busy, s_busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h, expected 0",
               {wr_en, wr_addr, wr_data, frame_ready, byte_count, overflow, busy, s_busy});
    end
    reset = 1'b0;
    href  = 1'b0;
    pclk  = 1'b0;
    cycles(4);
    model_clear();
    pulse_start();
    send_frame(1, 4, 8'h50);
    checks++;
    if (got_big.size() != exp_big.size() || got_big.size() == 0 || got_big[0] !== exp_big[0]) begin
      errors++;
      $display("FAIL midreset_restart: got %0d writes (first %h), expected %0d (first %h)",
               got_big.size(), (got_big.size() > 0) ? got_big[0] : wr_t'(0),
               exp_big.size(), exp_big[0]);
    end
    pulse_ack();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    pclk  = 1'b0;
    href  = 1'b0;
    vsync = 1'b0;
    data  = 8'h00;
    test_reset();
    test_nominal();
    test_mid_frame_start();
    test_overflow();
    test_odd_byte();
    test_handshake();
    test_reset_mid_capture();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
